// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks a low column across the keypad, debounces every key and
// queues press codes in a 4-entry FIFO that the CPU reads and pops over the word bus.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 65536,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] D,
  input  logic        A,
  input  logic [3:0]  be,
  input  logic        we,
  output logic [31:0] Dout,
  output logic [3:0]  col,
  input  logic [3:0]  row
);

  localparam int unsigned DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [2:0]  DebN    = 3'(DEBOUNCE_SCANS);

  logic [3:0]      row_s1_q, row_s2_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [15:0]     st_q, st_d;
  logic [2:0]      cnt_q [16];
  logic [2:0]      cnt_d [16];
  logic [3:0]      pend_q, pend_d;
  logic [1:0]      pend_col_q, pend_col_d;
  logic [3:0]      fifo_q [4];
  logic [3:0]      fifo_d [4];
  logic [1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [2:0]      count_q, count_d;
  logic            ovf_q, ovf_d;

  logic            push, push_ok, pop, pop_ok, ovf_clr;
  logic [3:0]      push_code, presses, key_idx, head;
  logic            raw_bit;
  logic            unused_bits;

  assign unused_bits = ^{D[31], D[29:0], be[2:1]};

  // Scan, debounce and pending-press drain.
  always_comb begin
    div_d      = div_q + 1'b1;
    col_idx_d  = col_idx_q;
    st_d       = st_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_col_d = pend_col_q;
    push       = 1'b0;
    push_code  = 4'h0;
    presses    = 4'h0;
    key_idx    = 4'h0;
    raw_bit    = 1'b0;

    for (int r = 0; r < 4; r++) begin
      if (pend_q[r] && !push) begin
        push      = 1'b1;
        push_code = {2'(r), pend_col_q};
        pend_d[r] = 1'b0;
      end
    end

    if (div_q == DivLast) begin
      div_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
      for (int r = 0; r < 4; r++) begin
        key_idx = {2'(r), col_idx_q};
        raw_bit = ~row_s2_q[r];
        if (raw_bit == st_q[key_idx]) begin
          cnt_d[key_idx] = 3'd0;
        end else if (cnt_q[key_idx] + 3'd1 == DebN) begin
          st_d[key_idx]  = raw_bit;
          cnt_d[key_idx] = 3'd0;
          presses[r]     = raw_bit;
        end else begin
          cnt_d[key_idx] = cnt_q[key_idx] + 3'd1;
        end
      end
      // The previous column's presses have always drained by now (SCAN_DIV >= 4).
      pend_d     = presses;
      pend_col_d = col_idx_q;
    end
  end

  // FIFO: a pop frees the slot first, so a full FIFO can accept a push in the same cycle.
  always_comb begin
    fifo_d  = fifo_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ovf_d   = ovf_q;
    pop     = we && !A && be[0];
    pop_ok  = pop && (count_q != 3'd0);
    ovf_clr = we && !A && be[3] && D[30];
    push_ok = push && ((count_q != 3'd4) || pop_ok);

    if (ovf_clr) ovf_d = 1'b0;
    if (pop_ok) rd_d = rd_q + 2'd1;
    if (push && !push_ok) ovf_d = 1'b1;
    if (push_ok) begin
      fifo_d[wr_q] = push_code;
      wr_d         = wr_q + 2'd1;
    end
    count_d = count_q + {2'b00, push_ok} - {2'b00, pop_ok};
  end

  always_comb begin
    head = (count_q != 3'd0) ? fifo_q[rd_q] : 4'h0;
    col  = ~(4'b0001 << col_idx_q);
    if (!A) Dout = {count_q != 3'd0, ovf_q, 19'b0, count_q, 4'b0, head};
    else    Dout = {16'b0, st_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      st_q       <= 16'h0;
      pend_q     <= 4'h0;
      pend_col_q <= 2'd0;
      rd_q       <= 2'd0;
      wr_q       <= 2'd0;
      count_q    <= 3'd0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 4'h0;
    end else begin
      row_s1_q   <= row;
      row_s2_q   <= row_s1_q;
      div_q      <= div_d;
      col_idx_q  <= col_idx_d;
      st_q       <= st_d;
      pend_q     <= pend_d;
      pend_col_q <= pend_col_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad model pulls rows low for held keys in the driven column.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] D;
  logic        A;
  logic [3:0]  be;
  logic        we;
  logic [31:0] Dout;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] press;
  int          checks = 0;
  int          errors = 0;

  keypad_scan #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .D   (D),
    .A   (A),
    .be  (be),
    .we  (we),
    .Dout(Dout),
    .col (col),
    .row (row)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && press[r*4+c]) row[r] = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic read_bus(input logic a, output logic [31:0] v);
    A = a;
    #1;
    v = Dout;
  endtask

  task automatic bus_write(input logic a, input logic [3:0] b, input logic [31:0] d);
    A  = a;
    be = b;
    D  = d;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    be = 4'h0;
    D  = 32'h0;
  endtask

  // Returns at the first negedge after column c becomes driven.
  task automatic wait_col(input int c);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << c);
    n = 0;
    while (col == tgt && n < 64) begin @(negedge clk); n++; end
    while (col != tgt && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL wait_col%0d timeout col=%b want %b", c, col, tgt);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [3:0]  exp;
    rst = 1'b1; press = 16'h0; we = 1'b0; A = 1'b0; be = 4'h0; D = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got %b want 1110", col); end
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_dout0 got %h want 0", v); end
    read_bus(1'b1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_dout1 got %h want 0", v); end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (col !== exp) begin errors++; $display("FAIL col_step%0d got %b want %b", k, col, exp); end
    end
  endtask

  task automatic test_single_press();
    logic [31:0] v;
    wait_col(2);
    press[6] = 1'b1;
    repeat (40) @(negedge clk);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h8000_0106) begin errors++; $display("FAIL single_status got %h want 80000106", v); end
    read_bus(1'b1, v);
    checks++;
    if (v !== 32'h0000_0040) begin errors++; $display("FAIL single_state got %h want 00000040", v); end
    bus_write(1'b0, 4'b0001, 32'h0);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL single_pop got %h want 0", v); end
    press[6] = 1'b0;
    repeat (48) @(negedge clk);
    read_bus(1'b1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL single_release_state got %h want 0", v); end
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL release_no_push got %h want 0", v); end
  endtask

  task automatic test_bounce();
    logic [31:0] v;
    wait_col(2);
    press[6] = 1'b1;
    repeat (4) @(negedge clk);
    press[6] = 1'b0;
    repeat (48) @(negedge clk);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL bounce_status got %h want 0", v); end
    read_bus(1'b1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL bounce_state got %h want 0", v); end
  endtask

  task automatic test_multi_press();
    logic [31:0] v;
    wait_col(1);
    press[1]  = 1'b1;
    press[13] = 1'b1;
    repeat (40) @(negedge clk);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h8000_0201) begin errors++; $display("FAIL multi_status got %h want 80000201", v); end
    read_bus(1'b1, v);
    checks++;
    if (v !== 32'h0000_2002) begin errors++; $display("FAIL multi_state got %h want 00002002", v); end
    bus_write(1'b0, 4'b0001, 32'h0);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h8000_010D) begin errors++; $display("FAIL multi_second got %h want 8000010d", v); end
    bus_write(1'b0, 4'b0001, 32'h0);
    press = 16'h0;
    repeat (48) @(negedge clk);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL multi_drained got %h want 0", v); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    int keys [5] = '{2, 7, 8, 13, 4};
    for (int i = 0; i < 5; i++) begin
      wait_col(keys[i] % 4);
      press[keys[i]] = 1'b1;
      repeat (40) @(negedge clk);
      press[keys[i]] = 1'b0;
      repeat (40) @(negedge clk);
    end
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'hC000_0402) begin errors++; $display("FAIL ovf_status got %h want c0000402", v); end
    // A write to the state word, and one without be[0], must not pop.
    bus_write(1'b1, 4'b1111, 32'hFFFF_FFFF);
    bus_write(1'b0, 4'b1000, 32'h4000_0000);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h8000_0402) begin errors++; $display("FAIL ovf_clear got %h want 80000402", v); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    wait_col(1);
    press[9] = 1'b1;
    // Second column-1 sample flips key 9; its push lands on the 21st edge.
    repeat (20) @(negedge clk);
    bus_write(1'b0, 4'b0001, 32'h0);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h8000_0407) begin errors++; $display("FAIL coll_status got %h want 80000407", v); end
    read_bus(1'b1, v);
    checks++;
    if (v !== 32'h0000_0200) begin errors++; $display("FAIL coll_state got %h want 00000200", v); end
    bus_write(1'b0, 4'b0001, 32'h0);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h8000_0308) begin errors++; $display("FAIL coll_pop1 got %h want 80000308", v); end
    bus_write(1'b0, 4'b0001, 32'h0);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h8000_020D) begin errors++; $display("FAIL coll_pop2 got %h want 8000020d", v); end
    bus_write(1'b0, 4'b0001, 32'h0);
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h8000_0109) begin errors++; $display("FAIL coll_tail got %h want 80000109", v); end
    press = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (col !== 4'b1110) begin errors++; $display("FAIL midrst_col got %b want 1110", col); end
    read_bus(1'b0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL midrst_dout0 got %h want 0", v); end
    read_bus(1'b1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL midrst_dout1 got %h want 0", v); end
    repeat (4) @(negedge clk);
    checks++;
    if (col !== 4'b1101) begin errors++; $display("FAIL midrst_div got %b want 1101", col); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_press();
    test_overflow();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Memory-mapped 4x4 matrix keypad scanner; the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one column low at a time, samples the active-low rows, and debounces each key.
- Pushes a key code on every debounced press into a 4-entry FIFO.
- CPU reads and pops the FIFO over the same word-addressed peripheral bus used by the display (D/A/be/we/Dout).

Parameters:
- SCAN_DIV, 65536, clk cycles each column is driven; must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive differing samples needed to flip a key's debounced state; 1..7.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- D  input  32  write data
- A  input  1  word address (0 = FIFO/status, 1 = live key state)
- be  input  4  byte enables for write
- we  input  1  write strobe
- Dout  output  32  read data, combinational from A
- col  output  4  column drive, active-low, exactly one bit low when scanning
- row  input  4  row sense, active-low (board pull-ups), asynchronous

Behaviour:
- Reset (rst=1 at posedge): div=0, col_idx=0, col=4'b1110 from the first cycle after reset, row synchronizer=4'hF, all debounced states and counters=0, FIFO empty, overflow=0, Dout reflects the reset contents.
- Row synchronization: two-flop synchronizer on row. raw = ~row_sync.
- Scan timing:
  - div counts 0..SCAN_DIV-1.
  - At div==SCAN_DIV-1: sample raw for the 4 keys of column col_idx, set div to 0, col_idx+1 (wraps mod 4).
  - col = ~(4'b0001 << col_idx).
  - Full sweep = 4*SCAN_DIV cycles.
- Key index k = row*4 + col_idx, 0..15.
- Debounce, per key on its sample:
  - raw==st: cnt<=0.
  - Otherwise cnt+1; if cnt+1==DEBOUNCE_SCANS then st<=raw, cnt<=0.
  - If the flip is to 1 (press), push k.
  - Releases never push.
- Simultaneous presses: several keys in the same column may flip on one sample. Push them in ascending row order, one per cycle, over the following cycles. The pending set is held in a 4-bit mask; SCAN_DIV>=4 guarantees it drains before the next sample.
- FIFO: 4 entries, 4-bit codes, count 0..4.
  - Push when full without a same-cycle pop: code dropped, overflow<=1.
  - Push and pop in the same cycle when full: pop then push; count stays 4, no overflow.
  - Pop when empty: no effect.
- Read map:
  - A=0: [31]=count!=0, [30]=overflow, [10:8]=count, [3:0]=head code (0 when empty), other bits 0.
  - A=1: [15:0]=debounced states st[15:0], other bits 0.
- Write map, only when we=1 and A=0; writes to A=1 are ignored:
  - be[0]=1: pop one entry.
  - be[3]=1 and D[30]=1: clear overflow. An overflow set in the same cycle wins over the clear.
  - Other be bits and D bits are ignored.
- rst mid-scan or mid-drain: all state returns to reset values and pending pushes are discarded.

Test Plan:
All tests use SCAN_DIV=4 and DEBOUNCE_SCANS=2, so a sweep is 16 cycles.
- Reset: hold rst 2 cycles with row=4'hF -> col=4'b1110, Dout(A=0)=0, Dout(A=1)=0; over the next 16 cycles col steps 1110, 1101, 1011, 0111, 1110.
- Single press, key row1/col2:
  - Stimulus: pull row[1] low whenever col[2]=0, held 3 sweeps.
  - Required: exactly one push; Dout(A=0)=0x8000_0106; Dout(A=1)=0x0000_0040.
  - Then write A=0, be=4'b0001 -> Dout(A=0)=0.
- Bounce rejection: row low for only 1 column-2 sample, then high -> no push, st[6] stays 0.
- Same-column multi-press: rows 0 and 3 low on column 1 -> codes 1 then 13 pushed; head=1, count=2; after a pop, head=13.
- Overflow:
  - Stimulus: press and release 5 distinct keys without popping.
  - Required: count=4, bit30=1, head=first key.
  - Then write A=0, be=4'b1000, D=0x4000_0000 -> bit30=0, count unchanged.
- Full push+pop collision: with FIFO full, pop exactly in the cycle a new press is pushed -> count stays 4, overflow stays 0, newest code at the tail. Then assert rst mid-sweep -> everything returns to reset values.
